// File: rtl/axi_wr_pkg.sv
// Shared AXI write-side constants, FSM state type and AWSIZE encoding helper
// for the AXI-Stream to AXI4 burst writer.
package axi_wr_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {FILL, AW, W, B} wr_state_t;

  // AWSIZE is log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned strb_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == strb_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axis_to_axi_wr_packer.sv
// Little-endian byte packer: collects bytes into a word and emits it, with its
// strobe mask, as a one-cycle registered commit when the word fills or on tlast.
module axis_byte_packer
  import axi_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [7:0]            s_byte,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  word_end,
  output logic [DATA_WIDTH-1:0] word_p1,
  output logic [STRB_WIDTH-1:0] strb_p1,
  output logic                  vld_p1,
  output logic                  last_p1
);

  localparam int IDX_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;

  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] lanes;
  logic [DATA_WIDTH-1:0] merged;
  logic [STRB_WIDTH-1:0] mask;

  assign word_end = (byte_idx == IDX_W'(STRB_WIDTH - 1));

  // Lanes above byte_idx are already zero because the lane register clears on commit.
  always_comb begin
    merged = lanes;
    merged[{byte_idx, 3'b000} +: 8] = s_byte;
    mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) mask[i] = (i <= int'(byte_idx));
  end

  // p0 -> p1: committed word boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      lanes    <= '0;
      word_p1  <= '0;
      strb_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clr) begin
        byte_idx <= '0;
        lanes    <= '0;
      end else if (s_valid) begin
        if (word_end || s_last) begin
          word_p1  <= merged;
          strb_p1  <= mask;
          vld_p1   <= 1'b1;
          last_p1  <= s_last;
          lanes    <= '0;
          byte_idx <= '0;
        end else begin
          lanes    <= merged;
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/axis_to_axi_wr.sv
// AXI-Stream byte input packed into DATA_WIDTH words and written to memory with
// AXI4 INCR bursts. Optional frame byte counter: define AXIS_WR_BYTE_CNT_EN.
module axis_to_axi_wr
  import axi_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  frame_done,
  output logic                  wr_err,
`ifdef AXIS_WR_BYTE_CNT_EN
  output logic [ADDR_WIDTH:0]   frame_bytes,
`endif
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  localparam int CNT_W       = $clog2(BURST_LEN + 1);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_BYTES = BURST_LEN * STRB_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ROUND_ADD  = ADDR_WIDTH'(BURST_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ROUND_ADD;

  wr_state_t             state;
  logic [CNT_W-1:0]      word_cnt;
  logic [BEAT_W-1:0]     beat;
  logic                  frame_end;
  logic                  hold;
  logic [STRB_WIDTH-1:0] tail_strb;
  logic [DATA_WIDTH-1:0] buffer [BURST_LEN];

  logic                  pk_word_end;
  logic [DATA_WIDTH-1:0] pk_word_p1;
  logic [STRB_WIDTH-1:0] pk_strb_p1;
  logic                  pk_vld_p1;
  logic                  pk_last_p1;
  logic                  acc;
  logic                  closing;
  logic                  b_done;
  logic [ADDR_WIDTH-1:0] used_bytes;
  logic [ADDR_WIDTH-1:0] next_seq;
  logic [ADDR_WIDTH-1:0] next_frame;
  logic                  bid_unused;

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = axi_size(STRB_WIDTH);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign bid_unused    = ^m_axi_bid;

  assign acc    = s_axis_tvalid && s_axis_tready;
  assign b_done = (state == B) && m_axi_bvalid;
  // A word still in the packer's output register is counted so input stops on time.
  assign closing = acc && (s_axis_tlast ||
                   (pk_word_end && ((word_cnt + CNT_W'(pk_vld_p1)) == CNT_W'(BURST_LEN - 1))));

  assign used_bytes = ADDR_WIDTH'(32'(word_cnt) * 32'(STRB_WIDTH));
  assign next_seq   = wr_addr + used_bytes;
  assign next_frame = (wr_addr + used_bytes + ROUND_ADD) & ALIGN_MASK;

  function automatic logic [STRB_WIDTH-1:0] beat_strb(input logic is_last, input logic fr_end,
                                                       input logic [STRB_WIDTH-1:0] tail);
    return (is_last && fr_end) ? tail : '1;
  endfunction

  axis_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (b_done),
    .s_byte   (s_axis_tdata),
    .s_valid  (acc),
    .s_last   (s_axis_tlast),
    .word_end (pk_word_end),
    .word_p1  (pk_word_p1),
    .strb_p1  (pk_strb_p1),
    .vld_p1   (pk_vld_p1),
    .last_p1  (pk_last_p1)
  );

  // p1 -> buffer: committed words land at word_cnt
  always_ff @(posedge clk) begin
    if (pk_vld_p1) buffer[word_cnt[BEAT_W-1:0]] <= pk_word_p1;
  end

`ifdef AXIS_WR_BYTE_CNT_EN
  logic [ADDR_WIDTH:0] fb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_cnt      <= '0;
      frame_bytes <= '0;
    end else if (b_done && frame_end) begin
      frame_bytes <= fb_cnt;
      fb_cnt      <= '0;
    end else if (acc) begin
      fb_cnt <= fb_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      wr_addr       <= BASE_ADDR;
      word_cnt      <= '0;
      beat          <= '0;
      frame_end     <= 1'b0;
      hold          <= 1'b0;
      tail_strb     <= '0;
      s_axis_tready <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
      frame_done    <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pk_vld_p1) begin
        word_cnt  <= word_cnt + CNT_W'(1);
        tail_strb <= pk_strb_p1;
        if (pk_last_p1) frame_end <= 1'b1;
      end
      case (state)
        FILL: begin
          if (closing) begin
            s_axis_tready <= 1'b0;
            hold          <= 1'b1;
          end else if (!hold) begin
            s_axis_tready <= 1'b1;
          end
          if ((word_cnt == CNT_W'(BURST_LEN)) || frame_end) begin
            state         <= AW;
            m_axi_awvalid <= 1'b1;
            m_axi_awaddr  <= wr_addr;
            m_axi_awlen   <= 8'(word_cnt - CNT_W'(1));
          end
        end
        AW: begin
          if (m_axi_awready) begin
            state         <= W;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            beat          <= '0;
            m_axi_wdata   <= buffer[0];
            m_axi_wlast   <= (word_cnt == CNT_W'(1));
            m_axi_wstrb   <= beat_strb(word_cnt == CNT_W'(1), frame_end, tail_strb);
          end
        end
        W: begin
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              state        <= B;
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_wstrb  <= '0;
              m_axi_bready <= 1'b1;
            end else begin
              beat        <= beat + BEAT_W'(1);
              m_axi_wdata <= buffer[beat + BEAT_W'(1)];
              m_axi_wlast <= ((CNT_W'(beat) + CNT_W'(2)) == word_cnt);
              m_axi_wstrb <= beat_strb((CNT_W'(beat) + CNT_W'(2)) == word_cnt,
                                       frame_end, tail_strb);
            end
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != AXI_RESP_OKAY) wr_err <= 1'b1;
            wr_addr       <= frame_end ? next_frame : next_seq;
            frame_done    <= frame_end;
            word_cnt      <= '0;
            frame_end     <= 1'b0;
            hold          <= 1'b0;
            m_axi_bready  <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
